// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive controller.
// States, the SYNC pattern and the PID nibble type live here so checkers can bind to them.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RECV_SYNC = 4'd1,
        CHK_SYNC  = 4'd2,
        RECV_PID  = 4'd3,
        CHK_PID   = 4'd4,
        RECV_BYTE = 4'd5,
        STORE     = 4'd6,
        EOP_WAIT  = 4'd7,
        ERR_WAIT  = 4'd8,
        ERR_IDLE  = 4'd9
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef logic [3:0] pid_t;

    // The timing stage stays enabled in every state between the start edge and the terminating EOP.
    function automatic logic state_rcving(input rx_state_t s);
        return (s != IDLE) && (s != EOP_WAIT) && (s != ERR_IDLE);
    endfunction

endpackage

// File: rtl/rx_bit_tracker.sv
// Counts shift_enable strobes since the last byte_received; byte_aligned marks a byte boundary.
// Used to tell a clean EOP (on a byte boundary) from a truncated byte.
module rx_bit_tracker (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic shift_enable,
    input  logic byte_received,
    output logic byte_aligned
);

    logic [2:0] bit_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count <= 3'd0;
        end else if (clear || byte_received) begin
            bit_count <= 3'd0;
        end else if (shift_enable) begin
            bit_count <= bit_count + 3'd1;
        end
    end

    assign byte_aligned = (bit_count == 3'd0);

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive-side framing FSM: SYNC -> PID -> data bytes -> EOP, with FIFO write strobes and error flag.
// Define USB_RX_PID_CHECK_EN to reject PID bytes whose high nibble is not the complement of the low nibble.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter  int MAX_BYTES = 64,
    localparam int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            d_edge,
    input  logic            eop,
    input  logic            shift_enable,
    input  logic            byte_received,
    input  logic [7:0]      rcv_data,
    output logic            rcving,
    output logic            w_enable,
    output logic            r_error,
    output pid_t            pid,
    output logic [CW-1:0]   byte_count,
    output rx_state_t       dbg_state
);

    rx_state_t state, state_n;
    logic      byte_aligned;
    logic      pid_ok;
    logic      eop_bit;
    logic      start;
    logic      at_max;

    rx_bit_tracker u_bit_tracker (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state == IDLE),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .byte_aligned (byte_aligned)
    );

`ifdef USB_RX_PID_CHECK_EN
    assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);
`else
    assign pid_ok = 1'b1;
`endif

    assign eop_bit = eop && shift_enable;
    assign start   = (state == IDLE) && d_edge;
    assign at_max  = (byte_count == CW'(MAX_BYTES));

    // A byte_received always wins over a coincident EOP; the EOP is picked up in the following RECV state.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (d_edge) state_n = RECV_SYNC;
            RECV_SYNC: begin
                if (byte_received) state_n = CHK_SYNC;
                else if (eop_bit)  state_n = ERR_IDLE;
            end
            CHK_SYNC:  state_n = (rcv_data == SYNC_BYTE) ? RECV_PID : ERR_WAIT;
            RECV_PID:  begin
                if (byte_received) state_n = CHK_PID;
                else if (eop_bit)  state_n = ERR_IDLE;
            end
            CHK_PID:   state_n = pid_ok ? RECV_BYTE : ERR_WAIT;
            RECV_BYTE: begin
                if (byte_received) state_n = STORE;
                else if (eop_bit)  state_n = byte_aligned ? EOP_WAIT : ERR_IDLE;
            end
            STORE:     state_n = at_max ? ERR_WAIT : RECV_BYTE;
            ERR_WAIT:  if (eop_bit) state_n = ERR_IDLE;
            EOP_WAIT,
            ERR_IDLE:  if (d_edge) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_error    <= 1'b0;
            pid        <= 4'h0;
            byte_count <= '0;
        end else if (start) begin
            r_error    <= 1'b0;
            pid        <= 4'h0;
            byte_count <= '0;
        end else begin
            if ((state_n == ERR_WAIT) || (state_n == ERR_IDLE)) r_error <= 1'b1;
            if ((state == CHK_PID) && pid_ok) pid <= rcv_data[3:0];
            if (w_enable) byte_count <= byte_count + CW'(1);
        end
    end

    assign w_enable  = (state == STORE) && !at_max;
    assign rcving    = state_rcving(state);
    assign dbg_state = state;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: a default instance and a MAX_BYTES=4 instance share one stimulus stream.
// Written bytes are checked against an expected queue; every comparison goes through check_val.
module tb_usb_rx_ctrl;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;

    logic       rcving_a, w_enable_a, r_error_a;
    pid_t       pid_a;
    logic [6:0] byte_count_a;
    rx_state_t  state_a;

    logic       rcving_b, w_enable_b, r_error_b;
    pid_t       pid_b;
    logic [2:0] byte_count_b;
    rx_state_t  state_b;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_a     = 0;
    int wr_b     = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    usb_rx_ctrl dut_a (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .byte_received(byte_received), .rcv_data(rcv_data),
        .rcving(rcving_a), .w_enable(w_enable_a), .r_error(r_error_a), .pid(pid_a),
        .byte_count(byte_count_a), .dbg_state(state_a)
    );

    usb_rx_ctrl #(.MAX_BYTES(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .byte_received(byte_received), .rcv_data(rcv_data),
        .rcving(rcving_b), .w_enable(w_enable_b), .r_error(r_error_b), .pid(pid_b),
        .byte_count(byte_count_b), .dbg_state(state_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (w_enable_a) begin
            wr_a++;
            check_val("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_val("write_data", 32'(rcv_data), 32'(exp_q.pop_front()));
        end
        if (w_enable_b) wr_b++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_d_edge();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
            tick();
        end
    endtask

    // Eight bit strobes; byte_received rides on the eighth. exp_we is the write strobe expected next cycle.
    task automatic send_byte(input logic [7:0] b, input bit push, input logic exp_we);
        if (push) exp_q.push_back(b);
        send_bits(7);
        shift_enable  = 1'b1;
        byte_received = 1'b1;
        rcv_data      = b;
        tick();
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        check_val("we_after_byte", 32'(w_enable_a), 32'(exp_we));
        tick();
        check_val("we_one_cycle", 32'(w_enable_a), 32'd0);
    endtask

    // EOP seen with a bit strobe, a second SE0 bit, then the bus returns to J.
    task automatic end_eop();
        eop          = 1'b1;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        check_val("rcving_fall", 32'(rcving_a), 32'd0);
        tick();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        eop          = 1'b0;
        tick();
        pulse_d_edge();
        tick();
    endtask

    task automatic start_packet();
        pulse_d_edge();
        check_val("rcving_rise", 32'(rcving_a), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_a;
        int base_b;

        tick();
        tick();
        check_val("rst_rcving", 32'(rcving_a), 32'd0);
        check_val("rst_w_enable", 32'(w_enable_a), 32'd0);
        check_val("rst_r_error", 32'(r_error_a), 32'd0);
        check_val("rst_pid", 32'(pid_a), 32'd0);
        check_val("rst_byte_count", 32'(byte_count_a), 32'd0);
        n_rst = 1'b1;
        tick();

        // Good packet: three data bytes
        base_a = wr_a; base_b = wr_b;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        check_val("t1_pid", 32'(pid_a), 32'h3);
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'hF0, 1'b1, 1'b1);
        end_eop();
        check_val("t1_writes", 32'(wr_a - base_a), 32'd3);
        check_val("t1_writes_b", 32'(wr_b - base_b), 32'd3);
        check_val("t1_byte_count", 32'(byte_count_a), 32'd3);
        check_val("t1_r_error", 32'(r_error_a), 32'd0);
        check_val("t1_state", 32'(state_a), 32'(IDLE));

        // Bad SYNC, then a good packet clears the error
        base_a = wr_a;
        start_packet();
        send_byte(8'h81, 1'b0, 1'b0);
        check_val("t2_r_error", 32'(r_error_a), 32'd1);
        check_val("t2_rcving", 32'(rcving_a), 32'd1);
        send_byte(8'h55, 1'b0, 1'b0);
        end_eop();
        check_val("t2_writes", 32'(wr_a - base_a), 32'd0);
        check_val("t2_r_error_held", 32'(r_error_a), 32'd1);
        check_val("t2_state", 32'(state_a), 32'(IDLE));
        start_packet();
        check_val("t2_r_error_clr", 32'(r_error_a), 32'd0);
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b1);
        end_eop();
        check_val("t2_byte_count", 32'(byte_count_a), 32'd1);
        check_val("t2_r_error_end", 32'(r_error_a), 32'd0);

        // PID byte whose nibbles are not complements
        base_a = wr_a;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC4, 1'b0, 1'b0);
`ifdef USB_RX_PID_CHECK_EN
        check_val("t3_r_error", 32'(r_error_a), 32'd1);
        check_val("t3_pid", 32'(pid_a), 32'h0);
        send_byte(8'h22, 1'b0, 1'b0);
        end_eop();
        check_val("t3_writes", 32'(wr_a - base_a), 32'd0);
`else
        check_val("t3_r_error", 32'(r_error_a), 32'd0);
        check_val("t3_pid", 32'(pid_a), 32'h4);
        send_byte(8'h22, 1'b1, 1'b1);
        end_eop();
        check_val("t3_writes", 32'(wr_a - base_a), 32'd1);
`endif

        // EOP after 5 bits of the second data byte
        base_a = wr_a;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b1);
        send_bits(5);
        check_val("t4_rcving_before", 32'(rcving_a), 32'd1);
        end_eop();
        check_val("t4_writes", 32'(wr_a - base_a), 32'd1);
        check_val("t4_r_error", 32'(r_error_a), 32'd1);

        // Five data bytes: default instance takes all, MAX_BYTES=4 instance overflows
        base_a = wr_a; base_b = wr_b;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
        check_val("t5_r_error_b", 32'(r_error_b), 32'd1);
        check_val("t5_rcving_b", 32'(rcving_b), 32'd1);
        check_val("t5_state_b", 32'(state_b), 32'(ERR_WAIT));
        end_eop();
        check_val("t5_writes_a", 32'(wr_a - base_a), 32'd5);
        check_val("t5_writes_b", 32'(wr_b - base_b), 32'd4);
        check_val("t5_byte_count_a", 32'(byte_count_a), 32'd5);
        check_val("t5_byte_count_b", 32'(byte_count_b), 32'd4);
        check_val("t5_r_error_a", 32'(r_error_a), 32'd0);
        check_val("t5_r_error_b_held", 32'(r_error_b), 32'd1);

        // Reset during the second data byte
        base_a = wr_a;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'h99, 1'b1, 1'b1);
        send_bits(3);
        #2;
        n_rst = 1'b0;
        #1;
        check_val("t6_rcving", 32'(rcving_a), 32'd0);
        check_val("t6_w_enable", 32'(w_enable_a), 32'd0);
        check_val("t6_r_error", 32'(r_error_a), 32'd0);
        check_val("t6_pid", 32'(pid_a), 32'd0);
        check_val("t6_byte_count", 32'(byte_count_a), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check_val("t6_writes", 32'(wr_a - base_a), 32'd1);
        base_a = wr_a;
        start_packet();
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        send_byte(8'hAB, 1'b1, 1'b1);
        end_eop();
        check_val("t6_next_writes", 32'(wr_a - base_a), 32'd1);
        check_val("t6_next_count", 32'(byte_count_a), 32'd1);
        check_val("t6_next_pid", 32'(pid_a), 32'h3);
        check_val("t6_next_r_error", 32'(r_error_a), 32'd0);

        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive-side control FSM for the USB full-speed receiver. It sits directly downstream of the bit-timing stage and consumes its `shift_enable` / `byte_received` strobes together with the edge, EOP and shift-register outputs. It frames each packet (SYNC → PID → data bytes → EOP), drives `rcving` back to the timing stage, and issues one-cycle write strobes to the RX FIFO. It flags framing, PID and length errors.

## Interface
- `MAX_BYTES`, default 64: maximum data bytes per packet after the PID; exceeding it is an error.
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `d_edge` in 1: single-cycle pulse on any D+/D- transition.
- `eop` in 1: SE0 currently on the bus (combinational from line sampler).
- `shift_enable` in 1: bit-sample strobe from the timing stage.
- `byte_received` in 1: one-cycle pulse when 8 bits have been shifted.
- `rcv_data` in 8: shift-register contents, LSB-first received order.
- `rcving` out 1: packet in progress; enables the timing stage.
- `w_enable` out 1: one-cycle FIFO write strobe; data is `rcv_data`.
- `r_error` out 1: sticky error flag for the current or most recent packet.
- `pid` out 4: captured PID nibble (`rcv_data[3:0]` of the PID byte).
- `byte_count` out `$clog2(MAX_BYTES+1)`: data bytes written for the current packet.

## Operation
- States: IDLE, RECV_SYNC, CHK_SYNC, RECV_PID, CHK_PID, RECV_BYTE, STORE, EOP_WAIT, ERR_WAIT, ERR_IDLE.
- IDLE:
  - `d_edge` → RECV_SYNC.
  - Clears `r_error`, `byte_count` and `pid` on that same edge.
- RECV_SYNC, RECV_PID, RECV_BYTE:
  - `rcving` = 1.
  - `byte_received` → CHK_SYNC, CHK_PID or STORE, respectively.
- CHK_SYNC (1 cycle):
  - `rcv_data == SYNC_BYTE` (8'h80) → RECV_PID.
  - Otherwise → ERR_WAIT.
- CHK_PID (1 cycle):
  - PID valid → latch `pid`, go to RECV_BYTE.
  - Otherwise → ERR_WAIT.
- STORE (1 cycle):
  - If `byte_count == MAX_BYTES` → ERR_WAIT, no write.
  - Otherwise `w_enable` = 1, `byte_count` +1, → RECV_BYTE.
- Partial-bit counter: 3 bits, counts `shift_enable` pulses since the last `byte_received`; cleared on `byte_received` and in IDLE.
- `eop && shift_enable`:
  - In RECV_SYNC or RECV_PID → ERR_IDLE, set `r_error`.
  - In RECV_BYTE with partial-bit count 0 → EOP_WAIT (clean end, zero data bytes allowed).
  - In RECV_BYTE with partial-bit count ≠ 0 → ERR_IDLE, set `r_error`.
- ERR_WAIT:
  - `r_error` = 1, `rcving` = 1; bytes are discarded.
  - `eop && shift_enable` → ERR_IDLE.
- EOP_WAIT and ERR_IDLE: `rcving` = 0; next `d_edge` (bus back to J) → IDLE.
- `r_error` holds until the next packet start in IDLE.
- Simultaneous events:
  - `eop && shift_enable` in the same cycle as `byte_received` → byte handled first; EOP is seen in the next RECV state.
  - `d_edge` is ignored in all states except IDLE, EOP_WAIT and ERR_IDLE.

## Timing
- All outputs registered or decoded from registered state. Reset: state IDLE; `rcving`, `w_enable`, `r_error` = 0; `pid` = 4'h0; `byte_count` = 0.
- `rcv_data` is valid in the cycle after `byte_received` (the CHK_*/STORE cycle) and stable until the next `shift_enable`.
- `w_enable` asserts exactly 1 cycle after `byte_received`, for exactly 1 cycle.
- `rcving` rises 1 cycle after the start `d_edge` and falls 1 cycle after the terminating `eop && shift_enable`.
- Reset mid-packet: immediate return to IDLE, no `w_enable` emitted.

## Configuration
- Macro `USB_RX_PID_CHECK_EN`.
- Defined: PID valid iff `rcv_data[7:4] == ~rcv_data[3:0]`; an invalid PID → ERR_WAIT.
- Undefined: every PID byte is accepted and only the low nibble is captured; the complement check logic is absent.

## Structure
- Package `usb_rx_pkg`: state enum `rx_state_t`, `SYNC_BYTE` = 8'h80, `pid_t` (4-bit) typedef.
- One sub-module, `rx_bit_tracker`: the 3-bit partial-bit counter. It outputs `byte_aligned` (count == 0).

## Test plan
- SYNC 8'h80, PID 8'hC3, 3 data bytes, clean EOP → 3 `w_enable` pulses, `byte_count` = 3, `pid` = 4'h3, `r_error` = 0.
- SYNC byte 8'h81 → ERR_WAIT with `r_error` = 1, no `w_enable`; after EOP and `d_edge` → IDLE; next good packet clears `r_error`.
- PID 8'hC4 with macro defined → `r_error` = 1, no writes; without macro → accepted, `pid` = 4'h4.
- EOP after 5 bits of the second data byte → 1 write, `r_error` = 1, `rcving` drops next cycle.
- `MAX_BYTES` = 4, 5 data bytes → exactly 4 writes, `r_error` = 1, `rcving` held until EOP.
- `n_rst` asserted during the second data byte → all outputs 0 immediately; the next packet is received normally.
